// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART frame receiver (8N1, or 8E1/8O1) with valid/ready byte output
// Define UART_RX_PARITY_EN to receive a parity bit and report parity_err.
module uart_rx_frame #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  // START holds CPB/2-1 cycles so its decision edge lands at T0+CPB/2.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2 - 2);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CPB - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q, rx_d_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          ferr_q, ferr_d;
  logic          done_q, done_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_out_q, ferr_out_d;
  logic          ovr_q, ovr_d;
  logic          fall, tick;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          perr_out_q, perr_out_d;
`endif

  assign fall = rx_d_q & ~rx_s_q;
  assign tick = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    ferr_d   = ferr_q;
    done_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d   = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d  = DATA;
          cnt_d    = BIT_LOAD;
          bitcnt_d = 4'd0;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d[bitcnt_q[2:0]] = rx_s_q;
          cnt_d = BIT_LOAD;
          if (bitcnt_q == 4'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          perr_d  = (^shift_q) ^ rx_s_q ^ 1'(PARITY_ODD);
          state_d = STOP;
          cnt_d   = BIT_LOAD;
        end
      end
`endif
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Back to IDLE immediately so the next start edge is not missed.
          ferr_d  = ~rx_s_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = ovr_q;
`ifdef UART_RX_PARITY_EN
    perr_out_d = perr_out_q;
`endif
    if (done_q) begin
      data_d     = shift_q;
      ferr_out_d = ferr_q;
      valid_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_out_d = perr_q;
`endif
      if (valid_q && !rx_ready) ovr_d = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_d_q     <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= 4'd0;
      shift_q    <= 8'h00;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      perr_out_q <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_d_q     <= rx_s_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
      perr_out_q <= perr_out_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_out_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE) || done_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_out_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame at CPB=10
module tb_uart_rx_frame;

  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int PX = CPB;
`else
  localparam int PX = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, busy;

  uart_rx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         exp_cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Caller is aligned 1 time unit after a rising edge; returns aligned the same way.
  task automatic send(input logic [7:0] d, input logic pbit, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
`ifdef UART_RX_PARITY_EN
    rx = pbit;
    repeat (CPB) @(posedge clk);
    #1;
`endif
    rx = stop;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  logic prev_valid = 1'b0;
  int   rise_cyc = 0;

  always @(negedge clk) begin
    if (rst_n && rx_valid && !prev_valid) rise_cyc = cyc;
    if (rst_n && rx_valid && rx_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got byte %02h expected no output", rx_data);
      end else begin
        mon_e = sb.pop_front();
        check("sb_data", 32'(rx_data), 32'(mon_e.data));
        check("sb_parity_err", 32'(parity_err), 32'(mon_e.perr));
        check("sb_frame_err", 32'(frame_err), 32'(mon_e.ferr));
        if (mon_e.exp_cyc >= 0) check("sb_valid_cycle", 32'(rise_cyc), 32'(mon_e.exp_cyc));
      end
    end
    prev_valid = rst_n && rx_valid;
  end

  int n0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    rst_n = 1'b1;
    idle(5);

    // 0x55, valid expected at T0+96 (T0 = entry cycle + 2)
    sb.push_back('{8'h55, 1'b0, 1'b0, cyc + 98 + PX});
    send(8'h55, 1'b0, 1'b1);
    idle(20);

`ifdef UART_RX_PARITY_EN
    sb.push_back('{8'hA5, 1'b0, 1'b0, cyc + 108});
    send(8'hA5, 1'b0, 1'b1);
    idle(20);
    sb.push_back('{8'hA5, 1'b1, 1'b0, cyc + 108});
    send(8'hA5, 1'b1, 1'b1);
    idle(20);
`endif

    // 3-cycle glitch: false start, busy drops at T0+5
    n0 = cyc;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    at_cycle(n0 + 3);
    check("glitch_busy_t0p1", 32'(busy), 1);
    at_cycle(n0 + 6);
    check("glitch_busy_t0p4", 32'(busy), 1);
    at_cycle(n0 + 7);
    check("glitch_busy_t0p5", 32'(busy), 0);
    repeat (120) @(negedge clk);
    check("glitch_no_valid", 32'(rx_valid), 0);
    @(posedge clk);
    #1;

    // framing error, then a clean frame
    sb.push_back('{8'h3C, 1'b0, 1'b1, cyc + 98 + PX});
    send(8'h3C, 1'b0, 1'b0);
    idle(30);
    sb.push_back('{8'h01, 1'b0, 1'b0, cyc + 98 + PX});
    send(8'h01, 1'b1, 1'b1);
    idle(20);

    // overrun: two back-to-back frames with the consumer stalled
    rx_ready = 1'b0;
    sb.push_back('{8'h22, 1'b0, 1'b0, -1});
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    check("ovr_rx_data", 32'(rx_data), 32'h22);
    check("ovr_rx_valid", 32'(rx_valid), 1);
    check("ovr_overrun", 32'(overrun), 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_dropped", 32'(rx_valid), 0);
    check("ovr_sticky", 32'(overrun), 1);
    idle(20);

    // reset during data bit 4 of 0xFF
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (4 * CPB + 5) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_rx_data", 32'(rx_data), 0);
    check("midrst_rx_valid", 32'(rx_valid), 0);
    check("midrst_parity_err", 32'(parity_err), 0);
    check("midrst_frame_err", 32'(frame_err), 0);
    check("midrst_overrun", 32'(overrun), 0);
    check("midrst_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20);
    sb.push_back('{8'h81, 1'b0, 1'b0, cyc + 98 + PX});
    send(8'h81, 1'b0, 1'b1);
    idle(20);
    check("post_rst_overrun", 32'(overrun), 0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
